seq_divider: RTL and testbench

//  Sequential unsigned divider. It is the inverse of the repeated-addition multiplier datapath

---
 rtl/seq_divider_pkg.sv | 12 +
 rtl/seq_divider_div_step.sv | 27 ++
 rtl/seq_divider.sv | 117 +++++++++++
 tb/tb_seq_divider.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared FSM state encoding and default width for the sequential divider
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  // The partial remainder is always below the divisor between steps, so only
  // its low WIDTH bits are carried; the shifted value needs the extra bit.
  logic [WIDTH:0] rs;
  logic           fits;

  // Shift in the next dividend bit, trial-subtract, keep the result if it fits.
  always_comb begin
    rs     = {r, q[WIDTH-1]};
    fits   = (rs >= {1'b0, d});
    r_next = fits ? (rs[WIDTH-1:0] - d) : rs[WIDTH-1:0];
    q_next = {q[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring unsigned divider, one quotient bit per clock
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic [WIDTH-1:0] wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_r, step_q;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (wr_q),
    .q      (wq_q),
    .d      (dvs_q),
    .r_next (step_r),
    .q_next (step_q)
  );

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d     = state_q;
    dvs_d       = dvs_q;
    wq_d        = wq_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            dvs_d   = divisor;
            wq_d    = dividend;
            wr_d    = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_CALC;
          end else begin
            // Zero divisor bypasses the iteration and reports immediately.
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_CALC: begin
        wq_d  = step_q;
        wr_d  = step_r;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quotient_d  = step_q;
          remainder_d = step_r;
          dbz_d       = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvs_q       <= '0;
      wq_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvs_q       <= dvs_d;
      wq_q        <= wq_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider against an arithmetic model
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  bit chk_en = 1'b0;

  // model: an accepted operation at edge E is busy after edges E..E+lat,
  // reports at edge E+lat, and the unit accepts again from edge E+lat+2
  int           edge_n = 0;
  bit           m_active = 1'b0;
  int           m_acc = 0;
  int           m_lat = 0;
  logic [W-1:0] m_pq = '0, m_pr = '0;
  bit           m_pz = 1'b0;
  logic [W-1:0] e_q = '0, e_r = '0;
  bit           e_z = 1'b0, e_busy = 1'b0, e_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      bit freed;
      @(posedge clk);
      edge_n++;
      if (rst) begin
        m_active = 1'b0;
        e_busy = 1'b0; e_done = 1'b0;
        e_q = '0; e_r = '0; e_z = 1'b0;
      end else begin
        freed  = 1'b0;
        e_done = 1'b0;
        if (m_active && edge_n == m_acc + m_lat + 1) begin
          m_active = 1'b0;
          freed = 1'b1;
        end
        if (!m_active && !freed && start) begin
          m_active = 1'b1;
          m_acc = edge_n;
          if (divisor == 0) begin
            m_lat = 0; m_pq = '1; m_pr = dividend; m_pz = 1'b1;
          end else begin
            m_lat = W; m_pq = dividend / divisor; m_pr = dividend % divisor; m_pz = 1'b0;
          end
        end
        if (m_active && edge_n == m_acc + m_lat) begin
          e_done = 1'b1;
          e_q = m_pq; e_r = m_pr; e_z = m_pz;
        end
        e_busy = m_active;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cyc busy", busy, e_busy);
        chk("cyc done", done, e_done);
        chk("cyc div_by_zero", div_by_zero, e_z);
        chk("cyc quotient", quotient, e_q);
        chk("cyc remainder", remainder, e_r);
        if (done) done_count++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, output int k);
    bit seen;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      if (done) seen = 1'b1;
      else begin
        tick(1);
        k++;
      end
    end
    chk({tag, " done seen"}, seen, 1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q_exp, input logic [W-1:0] r_exp,
                        input bit z_exp, input string tag);
    int k;
    start = 1'b1; dividend = a; divisor = b;
    tick(1);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    chk({tag, " busy"}, busy, 1);
    wait_done(tag, k);
    chk({tag, " latency"}, k, z_exp ? 0 : W);
    chk({tag, " quotient"}, quotient, q_exp);
    chk({tag, " remainder"}, remainder, r_exp);
    chk({tag, " div_by_zero"}, div_by_zero, z_exp);
    chk({tag, " model quotient"}, e_q, q_exp);
    chk({tag, " model remainder"}, e_r, r_exp);
    tick(1);
    chk({tag, " done one cycle"}, done, 0);
    chk({tag, " idle after"}, busy, 0);
  endtask

  function automatic logic [W-1:0] rand_dividend();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 40));
      default: return W'($urandom);
    endcase
  endfunction

  function automatic logic [W-1:0] rand_divisor();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int k, t1, t2, dc0;

    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);

    run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, "nominal");
    run_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, "max_div1");
    run_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, "max_divmax");
    run_op(16'd3, 16'd10, 16'd0, 16'd3, 1'b0, "small_over_big");
    run_op(16'd0, 16'd5, 16'd0, 16'd0, 1'b0, "zero_dividend");
    run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, "div_zero");

    // start pulse mid-run must be ignored
    dc0 = done_count;
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    tick(1);
    start = 1'b0;
    tick(7);
    start = 1'b1; dividend = 16'd50; divisor = 16'd5;
    tick(1);
    start = 1'b0;
    wait_done("busy_start", k);
    chk("busy_start quotient", quotient, 16'd14);
    chk("busy_start remainder", remainder, 16'd2);
    tick(3);
    chk("busy_start single done", done_count - dc0, 1);

    // reset mid-operation aborts without done
    dc0 = done_count;
    start = 1'b1; dividend = 16'd100; divisor = 16'd7;
    tick(1);
    start = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    tick(W + 4);
    chk("abort no done", done_count - dc0, 0);
    run_op(16'd1000, 16'd33, 16'd30, 16'd10, 1'b0, "after_abort");

    // start held high: back-to-back operations
    start = 1'b1; dividend = 16'd200; divisor = 16'd9;
    tick(1);
    wait_done("b2b first", k);
    t1 = edge_n;
    chk("b2b first quotient", quotient, 16'd22);
    chk("b2b first remainder", remainder, 16'd2);
    dividend = 16'd17; divisor = 16'd4;
    tick(2);
    start = 1'b0;
    wait_done("b2b second", k);
    t2 = edge_n;
    chk("b2b spacing", t2 - t1, W + 2);
    chk("b2b second quotient", quotient, 16'd4);
    chk("b2b second remainder", remainder, 16'd1);
    tick(1);
    chk("b2b done one cycle", done, 0);
    tick(2);

    // randomized traffic checked cycle by cycle against the model
    repeat (3000) begin
      start    = ($urandom_range(0, 2) == 0);
      dividend = rand_dividend();
      divisor  = rand_divisor();
      rst      = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    start = 1'b0;
    tick(W + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
